// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: sequencer / control FSM for the small accumulator CPU.
//
// Owns the program counter, fetches instruction words from the instruction
// memory over a req/ack handshake (wait states allowed, optional timeout),
// decodes ALU / branch / HALT / NOP instructions and drives the ALU opcode and
// register write enables. Free-run while run_i is high; one instruction per
// rising edge of step_i otherwise.
//
// Instruction layout: {class[1:0], opcode[3:0], operand[PC_W-1:0]}
//   class 00 ALU, 01 branch, 10 HALT, 11 NOP
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   run_i             free-run enable (level)
//   step_i            single-step request (rising edge)
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (= PC)
//   imem_ack_i        fetch data valid this cycle
//   imem_data_i       instruction word
//   z_i/c_i/v_i/n_i   registered ALU flags
//   alu_op_o          ALU operation
//   write_enable_a_o  write A register
//   write_enable_x_o  write X register
//   flags_we_o        update flag register
//   pc_o              current PC
//   busy_o            fetching or executing
//   halted_o          in HALT
//   illegal_o         one-cycle pulse on an illegal instruction
//   fault_o           sticky fetch-timeout fault

module cpu_seq_ctrl #(
    parameter int unsigned      PC_W        = 8,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    parameter int unsigned      TIMEOUT_CYC = 16,
    localparam int unsigned     INSTR_W     = 6 + PC_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic               step_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               z_i,
    input  logic               c_i,
    input  logic               v_i,
    input  logic               n_i,
    output logic [3:0]         alu_op_o,
    output logic               write_enable_a_o,
    output logic               write_enable_x_o,
    output logic               flags_we_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic               illegal_o,
    output logic               fault_o
);

    // ALU operation encoding
    localparam logic [3:0] OP_PASS_A     = 4'd0;
    localparam logic [3:0] OP_ADD        = 4'd1;
    localparam logic [3:0] OP_SUB        = 4'd2;
    localparam logic [3:0] OP_AND        = 4'd3;
    localparam logic [3:0] OP_OR         = 4'd4;
    localparam logic [3:0] OP_XOR        = 4'd5;
    localparam logic [3:0] OP_SHL_A      = 4'd6;
    localparam logic [3:0] OP_SHR_A      = 4'd7;
    localparam logic [3:0] OP_INC_REG_A  = 4'd8;
    localparam logic [3:0] OP_DEC_REG_A  = 4'd9;
    localparam logic [3:0] OP_MOVE_REG_AX = 4'd10;
    localparam logic [3:0] OP_MOVE_REG_XA = 4'd11;
    localparam logic [3:0] OP_PASS_B     = 4'd12;

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_HALT   = 2'b10;

    // Counter must be able to hold TIMEOUT_CYC itself.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               step_q;
    logic               fault_q;

    logic [1:0]       ir_cls;
    logic [3:0]       ir_opc;
    logic [PC_W-1:0]  ir_operand;
    logic             step_edge;
    logic [CNT_W-1:0] cnt_inc;
    logic             br_taken;
    logic             is_halt;

    assign {ir_cls, ir_opc, ir_operand} = ir_q;
    assign step_edge = step_i & ~step_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // EXEC-cycle decode; everything is zero outside EXEC.
    always_comb begin
        alu_op_o         = 4'd0;
        write_enable_a_o = 1'b0;
        write_enable_x_o = 1'b0;
        flags_we_o       = 1'b0;
        illegal_o        = 1'b0;
        br_taken         = 1'b0;
        is_halt          = 1'b0;
        if (state_q == StExec) begin
            unique case (ir_cls)
                CLS_ALU: begin
                    unique case (ir_opc)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL_A, OP_SHR_A,
                        OP_INC_REG_A, OP_DEC_REG_A: begin
                            alu_op_o         = ir_opc;
                            write_enable_a_o = 1'b1;
                            flags_we_o       = 1'b1;
                        end
                        OP_MOVE_REG_AX: begin
                            alu_op_o         = ir_opc;
                            write_enable_a_o = 1'b1;
                        end
                        OP_MOVE_REG_XA: begin
                            alu_op_o         = ir_opc;
                            write_enable_x_o = 1'b1;
                        end
                        OP_PASS_A, OP_PASS_B: alu_op_o = ir_opc;
                        default: illegal_o = 1'b1;
                    endcase
                end
                CLS_BRANCH: begin
                    if (ir_opc[3] || (ir_opc[2:0] == 3'd7)) begin
                        illegal_o = 1'b1;
                    end else begin
                        unique case (ir_opc[2:0])
                            3'd0:    br_taken = 1'b1;
                            3'd1:    br_taken = z_i;
                            3'd2:    br_taken = ~z_i;
                            3'd3:    br_taken = c_i;
                            3'd4:    br_taken = ~c_i;
                            3'd5:    br_taken = n_i;
                            3'd6:    br_taken = v_i;
                            default: br_taken = 1'b0;
                        endcase
                    end
                end
                CLS_HALT: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            step_q <= step_i;
            unique case (state_q)
                StIdle: begin
                    if (run_i || step_edge) state_q <= StFetch;
                end
                StFetch: begin
                    if (imem_ack_i) begin
                        ir_q    <= imem_data_i;
                        pc_q    <= pc_q + PC_W'(1);
                        cnt_q   <= '0;
                        state_q <= StExec;
                    end else begin
                        cnt_q <= cnt_inc;
                        if ((TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM)) begin
                            fault_q <= 1'b1;
                            state_q <= StHalt;
                        end
                    end
                end
                StExec: begin
                    // A taken branch overrides the increment done at fetch.
                    if (br_taken) pc_q <= ir_operand;
                    if (is_halt)    state_q <= StHalt;
                    else if (run_i) state_q <= StFetch;
                    else            state_q <= StIdle;
                end
                StHalt: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req_o  = (state_q == StFetch);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign busy_o      = (state_q == StFetch) || (state_q == StExec);
    assign halted_o    = (state_q == StHalt);
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

    localparam logic [1:0] CL_ALU = 2'b00;
    localparam logic [1:0] CL_BR  = 2'b01;
    localparam logic [1:0] CL_HLT = 2'b10;
    localparam logic [1:0] CL_NOP = 2'b11;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_MXA = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [13:0] imem_data;
    logic        z = 1'b0, c = 1'b0, v = 1'b0, n = 1'b0;
    logic [3:0]  alu_op;
    logic        we_a, we_x, flags_we;
    logic [7:0]  pc;
    logic        busy, halted, illegal, fault;

    logic [13:0] mem [256];
    logic        ack_en = 1'b1;
    int          ack_wait = 0;
    int          wait_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Memory responder: ack after ack_wait stalled request cycles.
    assign imem_ack  = imem_req && ack_en && (wait_cnt == ack_wait);
    assign imem_data = mem[imem_addr];
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    cpu_seq_ctrl #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .step_i(step),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
        .imem_data_i(imem_data), .z_i(z), .c_i(c), .v_i(v), .n_i(n),
        .alu_op_o(alu_op), .write_enable_a_o(we_a), .write_enable_x_o(we_x),
        .flags_we_o(flags_we), .pc_o(pc), .busy_o(busy), .halted_o(halted),
        .illegal_o(illegal), .fault_o(fault)
    );

    function automatic logic [13:0] ins(input logic [1:0] cl, input logic [3:0] op,
                                        input logic [7:0] arg);
        return {cl, op, arg};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = ins(CL_NOP, 4'd0, 8'd0);
    endtask

    // Leaves the DUT in IDLE at a negedge, one cycle after the reset edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", pc); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if ({busy, halted, fault, illegal} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, halted, fault, illegal}); end
        n_tests++; if ({alu_op, we_a, we_x, flags_we} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want 0", {alu_op, we_a, we_x, flags_we}); end
    endtask

    task automatic test_run();
        clear_mem();
        mem[0] = ins(CL_ALU, OP_ADD, 8'd0);
        mem[1] = ins(CL_ALU, OP_MXA, 8'd0);
        do_reset();
        run = 1'b1;
        @(negedge clk);
        n_tests++; if ({imem_req, imem_addr, busy} !== {1'b1, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL run_fetch0: got %b/%0h/%b want 1/0/1", imem_req, imem_addr, busy); end
        @(negedge clk);
        n_tests++; if ({alu_op, we_a, we_x, flags_we} !== {OP_ADD, 3'b101}) begin
            n_fail++; $display("FAIL run_exec_add: got %h want %h", {alu_op, we_a, we_x, flags_we}, {OP_ADD, 3'b101}); end
        n_tests++; if (pc !== 8'h01) begin n_fail++; $display("FAIL run_pc1: got %0h want 1", pc); end
        @(negedge clk);
        n_tests++; if ({imem_req, imem_addr, alu_op, we_a} !== {1'b1, 8'h01, 4'd0, 1'b0}) begin
            n_fail++; $display("FAIL run_fetch1: got %h want %h", {imem_req, imem_addr, alu_op, we_a}, {1'b1, 8'h01, 4'd0, 1'b0}); end
        @(negedge clk);
        n_tests++; if ({alu_op, we_a, we_x, flags_we} !== {OP_MXA, 3'b010}) begin
            n_fail++; $display("FAIL run_exec_mxa: got %h want %h", {alu_op, we_a, we_x, flags_we}, {OP_MXA, 3'b010}); end
        n_tests++; if (pc !== 8'h02) begin n_fail++; $display("FAIL run_pc2: got %0h want 2", pc); end
        repeat (2) @(negedge clk);
        n_tests++; if ({pc, alu_op, we_a, we_x, flags_we} !== {8'h03, 7'd0}) begin
            n_fail++; $display("FAIL run_exec_nop: got %h want %h", {pc, alu_op, we_a, we_x, flags_we}, {8'h03, 7'd0}); end
        run = 1'b0;
        @(negedge clk);
        n_tests++; if ({busy, imem_req} !== 2'b00) begin
            n_fail++; $display("FAIL run_stop_idle: got %b want 00", {busy, imem_req}); end
    endtask

    task automatic test_step();
        int reqs;
        clear_mem();
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL step_fetch: got %b want 1", imem_req); end
            @(negedge clk);
            n_tests++; if ({busy, imem_req, pc} !== {2'b10, 8'(k)}) begin
                n_fail++; $display("FAIL step_exec: got %h want %h", {busy, imem_req, pc}, {2'b10, 8'(k)}); end
            @(negedge clk);
            n_tests++; if ({busy, imem_req, pc} !== {2'b00, 8'(k)}) begin
                n_fail++; $display("FAIL step_idle: got %h want %h", {busy, imem_req, pc}, {2'b00, 8'(k)}); end
        end
        step = 1'b1;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        step = 1'b0;
        n_tests++; if (reqs !== 1) begin n_fail++; $display("FAIL step_held_fetches: got %0d want 1", reqs); end
        n_tests++; if ({busy, pc} !== {1'b0, 8'h03}) begin
            n_fail++; $display("FAIL step_held_pc: got %h want %h", {busy, pc}, {1'b0, 8'h03}); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            mem[5] = ins(CL_BR, 4'd1, 8'h40);
            z = (t == 0);
            do_reset();
            run = 1'b1;
            repeat (12) @(negedge clk);
            n_tests++; if ({busy, imem_req, pc} !== {2'b10, 8'h06}) begin
                n_fail++; $display("FAIL br_exec_state: got %h want %h", {busy, imem_req, pc}, {2'b10, 8'h06}); end
            n_tests++; if ({alu_op, we_a, we_x, flags_we, illegal} !== 8'd0) begin
                n_fail++; $display("FAIL br_no_writes: got %h want 0", {alu_op, we_a, we_x, flags_we, illegal}); end
            @(negedge clk);
            run = 1'b0;
            if (t == 0) begin
                n_tests++; if ({imem_req, pc} !== {1'b1, 8'h40}) begin
                    n_fail++; $display("FAIL br_taken_pc: got %h want %h", {imem_req, pc}, {1'b1, 8'h40}); end
            end else begin
                n_tests++; if ({imem_req, pc} !== {1'b1, 8'h06}) begin
                    n_fail++; $display("FAIL br_not_taken_pc: got %h want %h", {imem_req, pc}, {1'b1, 8'h06}); end
            end
        end
        z = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wait_timeout();
        int reqs;
        logic seen;
        clear_mem();
        mem[0] = ins(CL_ALU, OP_ADD, 8'd0);
        ack_wait = 3;
        do_reset();
        run = 1'b1;
        reqs = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (alu_op == OP_ADD) begin seen = 1'b1; break; end
            if (imem_req) reqs++;
        end
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wait_exec_seen: got %b want 1", seen); end
        n_tests++; if (reqs !== 4) begin n_fail++; $display("FAIL wait_req_cycles: got %0d want 4", reqs); end
        n_tests++; if ({pc, we_a, flags_we} !== {8'h01, 2'b11}) begin
            n_fail++; $display("FAIL wait_exec: got %h want %h", {pc, we_a, flags_we}, {8'h01, 2'b11}); end
        run = 1'b0;
        ack_wait = 0;
        // No ack ever: fault after exactly 16 request cycles.
        do_reset();
        ack_en = 1'b0;
        run = 1'b1;
        reqs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) break;
            if (imem_req) reqs++;
        end
        n_tests++; if (reqs !== 16) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 16", reqs); end
        n_tests++; if ({fault, halted, busy, imem_req, pc} !== {4'b1100, 8'h00}) begin
            n_fail++; $display("FAIL to_halt_state: got %h want %h", {fault, halted, busy, imem_req, pc}, {4'b1100, 8'h00}); end
        run = 1'b0;
        ack_en = 1'b1;
        do_reset();
        n_tests++; if ({fault, halted} !== 2'b00) begin
            n_fail++; $display("FAIL to_reset_clear: got %b want 00", {fault, halted}); end
    endtask

    task automatic test_boundary();
        clear_mem();
        mem[0] = ins(CL_ALU, 4'd13, 8'd0);   // undefined ALU opcode
        mem[1] = ins(CL_BR, 4'd7, 8'h40);    // condition 7
        mem[2] = ins(CL_BR, 4'd8, 8'h40);    // opcode[3] set
        mem[3] = ins(CL_BR, 4'd0, 8'hFF);    // always
        do_reset();
        run = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if ({illegal, alu_op, we_a, we_x, flags_we, pc} !== {8'h80, 8'h01}) begin
            n_fail++; $display("FAIL bnd_ill_alu: got %h want %h", {illegal, alu_op, we_a, we_x, flags_we, pc}, {8'h80, 8'h01}); end
        @(negedge clk);
        n_tests++; if ({illegal, imem_addr} !== {1'b0, 8'h01}) begin
            n_fail++; $display("FAIL bnd_ill_pulse: got %h want %h", {illegal, imem_addr}, {1'b0, 8'h01}); end
        @(negedge clk);
        n_tests++; if ({illegal, we_a, we_x, flags_we, pc} !== {4'b1000, 8'h02}) begin
            n_fail++; $display("FAIL bnd_ill_cond7: got %h want %h", {illegal, we_a, we_x, flags_we, pc}, {4'b1000, 8'h02}); end
        @(negedge clk);
        n_tests++; if ({imem_req, pc} !== {1'b1, 8'h02}) begin
            n_fail++; $display("FAIL bnd_cond7_pc: got %h want %h", {imem_req, pc}, {1'b1, 8'h02}); end
        @(negedge clk);
        n_tests++; if ({illegal, pc} !== {1'b1, 8'h03}) begin
            n_fail++; $display("FAIL bnd_ill_op3: got %h want %h", {illegal, pc}, {1'b1, 8'h03}); end
        repeat (2) @(negedge clk);
        n_tests++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL bnd_jmp_legal: got %b want 0", illegal); end
        @(negedge clk);
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL bnd_jmp_ff: got %h want %h", {imem_req, imem_addr}, {1'b1, 8'hFF}); end
        @(negedge clk);
        run = 1'b0;
        n_tests++; if (pc !== 8'h00) begin n_fail++; $display("FAIL bnd_pc_wrap: got %0h want 0", pc); end
        @(negedge clk);
    endtask

    task automatic test_halt();
        int reqs;
        clear_mem();
        mem[0] = ins(CL_HLT, 4'd0, 8'd0);
        do_reset();
        run = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if ({busy, halted} !== 2'b10) begin
            n_fail++; $display("FAIL halt_exec: got %b want 10", {busy, halted}); end
        @(negedge clk);
        n_tests++; if ({halted, busy, pc} !== {2'b10, 8'h01}) begin
            n_fail++; $display("FAIL halt_enter: got %h want %h", {halted, busy, pc}, {2'b10, 8'h01}); end
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            run = i[0];
            step = i[1];
            @(negedge clk);
            if (imem_req || !halted) reqs++;
        end
        run = 1'b0; step = 1'b0;
        n_tests++; if (reqs !== 0) begin n_fail++; $display("FAIL halt_sticky: got %0d leaks want 0", reqs); end
        n_tests++; if ({halted, pc} !== {1'b1, 8'h01}) begin
            n_fail++; $display("FAIL halt_pc: got %h want %h", {halted, pc}, {1'b1, 8'h01}); end
        // Reset landing in the middle of a stalled fetch.
        do_reset();
        ack_en = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_fetch_req: got %b want 1", imem_req); end
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        n_tests++; if ({pc, imem_req, fault, busy, halted} !== {8'h00, 4'b0000}) begin
            n_fail++; $display("FAIL mid_fetch_reset: got %h want %h", {pc, imem_req, fault, busy, halted}, {8'h00, 4'b0000}); end
        @(negedge clk);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", imem_req); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_mem();
        test_reset();
        test_run();
        test_step();
        test_branch();
        test_wait_timeout();
        test_boundary();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Parametrised successor to the two-state CPU control FSM.
- Owns the program counter and fetches instructions from an instruction memory through a req/ack handshake with wait states and a timeout.
- Decodes ALU, branch, HALT and NOP instructions and drives the ALU opcode and register write enables.
- Supports a free-run mode and a single-step mode. It sits between the instruction memory and the datapath (ALU, A/X registers, flag register).

Parameters:
- PC_W, 8, program counter and branch-target width.
- RESET_PC, 0, PC value after reset (PC_W bits).
- TIMEOUT_CYC, 16, fetch cycles without ack before a fault; 0 disables the timeout.
- Localparam INSTR_W = 6+PC_W. Layout is {class[1:0], opcode[3:0], operand[PC_W-1:0]}.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- run_i  in  1  level; free-run while high
- step_i  in  1  a rising edge executes exactly one instruction
- imem_req_o  out  1  fetch request
- imem_addr_o  out  PC_W  fetch address (= PC)
- imem_ack_i  in  1  fetch data valid this cycle
- imem_data_i  in  INSTR_W  instruction word
- z_i, c_i, v_i, n_i  in  1 each  registered ALU flags
- alu_op_o  out  4  ALU operation (encoding per operations.vh)
- write_enable_a_o  out  1  write A
- write_enable_x_o  out  1  write X
- flags_we_o  out  1  update flag register
- pc_o  out  PC_W  current PC
- busy_o  out  1  state is not IDLE and not HALT
- halted_o  out  1  state is HALT
- illegal_o  out  1  one-cycle pulse on an illegal instruction
- fault_o  out  1  sticky fetch-timeout fault

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, PC=RESET_PC, instruction register=0, timeout counter=0, step edge register=0, fault_o=0.
  - All outputs are 0 except pc_o=RESET_PC.
  - Reset applies from any state, including mid-fetch. imem_req_o is low in the first cycle after reset.
- Step edge detect: step_edge = step_i & ~step_d. step_d is registered every cycle in every state.
- IDLE:
  - run_i | step_edge -> FETCH. Both high at once behaves the same as run_i alone.
  - A step_edge in any other state is ignored.
- FETCH:
  - imem_req_o=1 and imem_addr_o=PC.
  - On imem_ack_i: latch imem_data_i, PC <= PC+1 (wraps modulo 2^PC_W), clear the counter, -> EXEC.
  - Without ack: the counter increments. When TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC, set fault_o and go to HALT; PC is unchanged.
  - imem_ack_i is ignored whenever imem_req_o=0.
- EXEC (exactly one cycle); all outputs here are combinational from the latched instruction:
  - class 00, ALU instruction: alu_op_o=opcode.
    - ADD/SUB/AND/OR/XOR/SHL_A/SHR_A/INC_REG_A/DEC_REG_A: write_enable_a_o=1, flags_we_o=1.
    - MOVE_REG_AX: write_enable_a_o=1 only.
    - MOVE_REG_XA: write_enable_x_o=1 only.
    - PASS_A/PASS_B: no writes.
    - Any other opcode: alu_op_o=0, no writes, illegal_o=1.
  - class 01, branch: opcode[2:0] selects the condition: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 V.
    - Flags are sampled in EXEC.
    - Taken: PC <= operand, overriding the fetch increment. Not taken: PC keeps PC+1.
    - Condition 7 or opcode[3]=1 is illegal: illegal_o=1, PC is unchanged.
    - Branches assert no write enables.
  - class 10, HALT: go to HALT.
  - class 11, NOP: nothing.
  - Next state: HALT for the HALT instruction. Otherwise FETCH if run_i=1, else IDLE.
- HALT: terminal. Only rst_i leaves it. run_i and step_i are ignored.
- Throughput: 2 cycles per instruction with zero-wait memory, plus N cycles for N wait states.
- Outputs in IDLE, FETCH and HALT: alu_op_o=0 and all write enables=0.

Test Plan:
- Reset then run_i=1; memory returns ACK in the first FETCH cycle with program [ADD, MOVE_REG_XA, NOP] at 0..2 -> EXEC every 2nd cycle; cycle 2: alu_op=ADD, we_a=1, flags_we=1; cycle 4: we_x=1; pc_o reads 1, 2, 3 after each fetch.
- run_i=0, two step_i pulses; step_i held high for 10 cycles -> each pulse gives exactly one FETCH+EXEC then returns to IDLE; holding step_i high gives only one instruction.
- Branch-if-Z to 0x40 with z_i=1, then the same with z_i=0 at PC 5 -> PC=0x40 when taken, PC=6 when not; no write enables asserted.
- Ack delayed 3 cycles; separately ack never arrives with TIMEOUT_CYC=16 -> req held 4 cycles then EXEC; no-ack case goes to HALT after 16 cycles with fault_o=1, halted_o=1, PC unchanged.
- PC=2^PC_W-1 fetching a NOP; illegal ALU opcode; branch condition 7 -> PC wraps to 0; illegal_o pulses 1 cycle with no writes.
- HALT instruction, then run_i and step_i toggled, then rst_i asserted mid-FETCH -> stays halted until reset; after reset pc_o=RESET_PC, req=0, fault_o=0.
